// File: rtl/memctrl_pkg.sv
// Shared types and helpers for the memory controller: FSM states, access sizes
// and byte-lane manipulation on 16-bit memory words.
package memctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_LO,
        RD_HI,
        RD_WAIT,
        WR_LO,
        WR_HI,
        RMW_WAIT,
        RMW_WR,
        RESP
    } memctrl_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    function automatic logic [7:0] byte_extract(input logic [15:0] half, input logic sel);
        return sel ? half[15:8] : half[7:0];
    endfunction

    function automatic logic [15:0] byte_merge(input logic [15:0] half, input logic [7:0] b,
                                               input logic sel);
        return sel ? {b, half[7:0]} : {half[15:8], b};
    endfunction

endpackage

// File: rtl/memctrl.sv
// Arbitrates instruction fetch and load/store onto one 16-bit synchronous memory,
// splitting word accesses and doing read-modify-write for byte stores.
module memctrl
    import memctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    IF_MEMCTRL_req,
    input  logic [ADDR_WIDTH:0]     IF_MEMCTRL_addr,
    output logic                    MEMCTRL_IF_valid,
    output logic [DATA_WIDTH-1:0]   MEMCTRL_IF_data,
    input  logic                    EX_MEMCTRL_req,
    input  logic                    EX_MEMCTRL_we,
    input  logic [1:0]              EX_MEMCTRL_size,
    input  logic [ADDR_WIDTH:0]     EX_MEMCTRL_addr,
    input  logic [2*DATA_WIDTH-1:0] EX_MEMCTRL_wdata,
    output logic                    MEMCTRL_EX_done,
    output logic                    MEMCTRL_EX_err,
    output logic [2*DATA_WIDTH-1:0] MEMCTRL_EX_rdata,
    input  logic [DATA_WIDTH-1:0]   MEM_MEMCTRL_from_mem_data,
    output logic                    MEMCTRL_MEM_to_mem_read_enable,
    output logic                    MEMCTRL_MEM_to_mem_write_enable,
    output logic                    MEMCTRL_MEM_to_mem_mem_enable,
    output logic [ADDR_WIDTH-1:0]   MEMCTRL_MEM_to_mem_address,
    output logic [DATA_WIDTH-1:0]   MEMCTRL_MEM_to_mem_data
);

    localparam logic [ADDR_WIDTH-1:0] HW_ONE = 1;

    memctrl_state_t          r_state;
    logic                    r_fetch;
    logic                    r_we;
    logic [1:0]              r_size;
    logic [ADDR_WIDTH:0]     r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata_hi;
    logic [7:0]              r_wbyte;
    logic [DATA_WIDTH-1:0]   r_lo;

    logic                    r_if_valid;
    logic [DATA_WIDTH-1:0]   r_if_data;
    logic                    r_ex_done;
    logic                    r_ex_err;
    logic [2*DATA_WIDTH-1:0] r_ex_rdata;
    logic                    r_mem_en;
    logic                    r_mem_rd;
    logic                    r_mem_wr;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_data;

    logic                    w_ex_misaligned;
    logic [ADDR_WIDTH-1:0]   w_hw;
    logic [ADDR_WIDTH-1:0]   w_hw_next;

    assign w_ex_misaligned = (EX_MEMCTRL_size == 2'b11)
                          || (EX_MEMCTRL_size == SIZE_HALF && EX_MEMCTRL_addr[0])
                          || (EX_MEMCTRL_size == SIZE_WORD && EX_MEMCTRL_addr[1:0] != 2'b00);
    assign w_hw      = r_addr[ADDR_WIDTH:1];
    assign w_hw_next = w_hw + HW_ONE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch    <= 1'b0;
            r_we       <= 1'b0;
            r_size     <= SIZE_BYTE;
            r_addr     <= '0;
            r_wdata_hi <= '0;
            r_wbyte    <= '0;
            r_lo       <= '0;
            r_if_valid <= 1'b0;
            r_if_data  <= '0;
            r_ex_done  <= 1'b0;
            r_ex_err   <= 1'b0;
            r_ex_rdata <= '0;
            r_mem_en   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            // Strobes and response pulses are single-cycle unless re-asserted below.
            r_mem_en   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_if_valid <= 1'b0;
            r_ex_done  <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (EX_MEMCTRL_req) begin
                        r_fetch    <= 1'b0;
                        r_we       <= EX_MEMCTRL_we;
                        r_size     <= EX_MEMCTRL_size;
                        r_addr     <= EX_MEMCTRL_addr;
                        r_wdata_hi <= EX_MEMCTRL_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
                        r_wbyte    <= EX_MEMCTRL_wdata[7:0];
                        if (w_ex_misaligned) begin
                            r_ex_done  <= 1'b1;
                            r_ex_err   <= 1'b1;
                            r_ex_rdata <= '0;
                            r_state    <= RESP;
                        end else if (EX_MEMCTRL_we && EX_MEMCTRL_size != SIZE_BYTE) begin
                            r_mem_en   <= 1'b1;
                            r_mem_wr   <= 1'b1;
                            r_mem_addr <= EX_MEMCTRL_addr[ADDR_WIDTH:1];
                            r_mem_data <= EX_MEMCTRL_wdata[DATA_WIDTH-1:0];
                            r_state    <= WR_LO;
                        end else begin
                            // Loads and byte stores both start by reading the low halfword.
                            r_mem_en   <= 1'b1;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= EX_MEMCTRL_addr[ADDR_WIDTH:1];
                            r_state    <= RD_LO;
                        end
                    end else if (IF_MEMCTRL_req) begin
                        r_fetch    <= 1'b1;
                        r_we       <= 1'b0;
                        r_size     <= SIZE_HALF;
                        r_addr     <= IF_MEMCTRL_addr;
                        r_mem_en   <= 1'b1;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= IF_MEMCTRL_addr[ADDR_WIDTH:1];
                        r_state    <= RD_LO;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RD_LO: begin
                    if (r_we) begin
                        r_state <= RMW_WAIT;
                    end else if (r_size == SIZE_WORD) begin
                        r_mem_en   <= 1'b1;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_hw_next;
                        r_state    <= RD_HI;
                    end else begin
                        r_state <= RD_WAIT;
                    end
                end
                RD_HI: begin
                    r_lo    <= MEM_MEMCTRL_from_mem_data;
                    r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    r_state <= RESP;
                    if (r_fetch) begin
                        r_if_valid <= 1'b1;
                        r_if_data  <= MEM_MEMCTRL_from_mem_data;
                    end else begin
                        r_ex_done <= 1'b1;
                        r_ex_err  <= 1'b0;
                        case (r_size)
                            SIZE_BYTE: r_ex_rdata <= {{(2*DATA_WIDTH-8){1'b0}},
                                                      byte_extract(MEM_MEMCTRL_from_mem_data, r_addr[0])};
                            SIZE_WORD: r_ex_rdata <= {MEM_MEMCTRL_from_mem_data, r_lo};
                            default:   r_ex_rdata <= {{DATA_WIDTH{1'b0}}, MEM_MEMCTRL_from_mem_data};
                        endcase
                    end
                end
                WR_LO: begin
                    if (r_size == SIZE_WORD) begin
                        r_mem_en   <= 1'b1;
                        r_mem_wr   <= 1'b1;
                        r_mem_addr <= w_hw_next;
                        r_mem_data <= r_wdata_hi;
                        r_state    <= WR_HI;
                    end else begin
                        r_ex_done  <= 1'b1;
                        r_ex_err   <= 1'b0;
                        r_ex_rdata <= '0;
                        r_state    <= RESP;
                    end
                end
                RMW_WAIT: begin
                    r_mem_en   <= 1'b1;
                    r_mem_wr   <= 1'b1;
                    r_mem_addr <= w_hw;
                    r_mem_data <= byte_merge(MEM_MEMCTRL_from_mem_data, r_wbyte, r_addr[0]);
                    r_state    <= RMW_WR;
                end
                WR_HI, RMW_WR: begin
                    r_ex_done  <= 1'b1;
                    r_ex_err   <= 1'b0;
                    r_ex_rdata <= '0;
                    r_state    <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MEMCTRL_IF_valid                = r_if_valid;
    assign MEMCTRL_IF_data                 = r_if_data;
    assign MEMCTRL_EX_done                 = r_ex_done;
    assign MEMCTRL_EX_err                  = r_ex_err;
    assign MEMCTRL_EX_rdata                = r_ex_rdata;
    assign MEMCTRL_MEM_to_mem_read_enable  = r_mem_rd;
    assign MEMCTRL_MEM_to_mem_write_enable = r_mem_wr;
    assign MEMCTRL_MEM_to_mem_mem_enable   = r_mem_en;
    assign MEMCTRL_MEM_to_mem_address      = r_mem_addr;
    assign MEMCTRL_MEM_to_mem_data         = r_mem_data;

endmodule
